// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back always wins; multi-cycle results wait in a small FIFO.
// Optional starvation stall request is enabled by defining WB_ARB_STARVE_EN.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        McValid,
  input  logic [4:0]  McRd,
  input  logic [31:0] McData,
  output logic        McReady,
  output logic        RfWE,
  output logic [4:0]  RfA3,
  output logic [31:0] RfWD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  output logic        Busy1,
  output logic        Busy2,
  output logic        StallReq
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_vld;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PW-1:0]    r_rptr, r_wptr;
  logic [CW-1:0]    r_count;

  logic             w_pipe_act, w_push, w_found, w_mc_wr;
  logic [CW-1:0]    w_off, w_lead, w_pop_n;
  logic [PW-1:0]    w_head;
  logic [DEPTH-1:0] w_vld_nxt;

  assign w_pipe_act = RegWriteW && (RdW != 5'd0);
  assign McReady    = rst_n && (r_count < CW'(DEPTH));
  assign w_push     = McValid && McReady && (McRd != 5'd0);

  // Oldest still-valid entry; killed entries ahead of it are dropped in the same cycle.
  always_comb begin
    logic [PW-1:0] idx;
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = PW'((int'(r_rptr) + k) % DEPTH);
      if (!w_found && (k < int'(r_count)) && r_vld[idx]) begin
        w_found = 1'b1;
        w_off   = CW'(k);
      end
    end
  end

  assign w_lead  = w_found ? w_off : r_count;
  assign w_head  = PW'((int'(r_rptr) + int'(w_off)) % DEPTH);
  assign w_mc_wr = !w_pipe_act && w_found;
  assign w_pop_n = w_lead + CW'(w_mc_wr);

  always_comb begin
    logic [PW-1:0] idx;
    w_vld_nxt = r_vld;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_pipe_act && (r_rd[i] == RdW)) w_vld_nxt[i] = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = PW'((int'(r_rptr) + k) % DEPTH);
      if (k < int'(w_pop_n)) w_vld_nxt[idx] = 1'b0;
    end
    if (w_push) w_vld_nxt[r_wptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_vld   <= w_vld_nxt;
      r_rptr  <= PW'((int'(r_rptr) + int'(w_pop_n)) % DEPTH);
      if (w_push) r_wptr <= PW'((int'(r_wptr) + 1) % DEPTH);
      r_count <= r_count + CW'(w_push) - w_pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= McRd;
      r_data[r_wptr] <= McData;
    end
  end

  always_comb begin
    RfWE = 1'b0;
    RfA3 = '0;
    RfWD = '0;
    if (rst_n) begin
      if (w_pipe_act) begin
        RfWE = RegWriteW;
        RfA3 = RdW;
        RfWD = ResultW;
      end else if (w_mc_wr) begin
        RfWE = 1'b1;
        RfA3 = r_rd[w_head];
        RfWD = r_data[w_head];
      end
    end
  end

  // Only registered entries count; the result offered this cycle is deliberately ignored.
  always_comb begin
    Busy1 = 1'b0;
    Busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (Rs1D != 5'd0) && (r_rd[i] == Rs1D)) Busy1 = 1'b1;
      if (r_vld[i] && (Rs2D != 5'd0) && (r_rd[i] == Rs2D)) Busy2 = 1'b1;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_mc_wr || (r_count == '0)) begin
      r_starve <= '0;
    end else if (w_pipe_act && (r_starve != SW'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign StallReq = (r_starve == SW'(STARVE_LIMIT));
`else
  assign StallReq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=8).
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        McValid;
  logic [4:0]  McRd;
  logic [31:0] McData;
  logic        McReady;
  logic        RfWE;
  logic [4:0]  RfA3;
  logic [31:0] RfWD;
  logic [4:0]  Rs1D, Rs2D;
  logic        Busy1, Busy2, StallReq;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .McValid(McValid), .McRd(McRd), .McData(McData), .McReady(McReady),
    .RfWE(RfWE), .RfA3(RfA3), .RfWD(RfWD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Busy1(Busy1), .Busy2(Busy2),
    .StallReq(StallReq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    McValid = 1'b0; McRd = '0; McData = '0;
    Rs1D = '0; Rs2D = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] val);
    RegWriteW = 1'b1; RdW = rd; ResultW = val;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] val);
    McValid = 1'b1; McRd = rd; McData = val;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // reset holds outputs low whatever the inputs do
    pipe(5'd5, 32'h1234); offer(5'd4, 32'h1); Rs1D = 5'd4; Rs2D = 5'd5;
    tick(); tick(); #1;
    chk("rst_rfwe", RfWE, 0);
    chk("rst_ready", McReady, 0);
    chk("rst_busy1", Busy1, 0);
    chk("rst_busy2", Busy2, 0);
    chk("rst_stall", StallReq, 0);
    chk("rst_a3", RfA3, 0);
    rst_n = 1'b1; McValid = 1'b0; #1;
    chk("rel_rfwe", RfWE, 1);
    chk("rel_a3", RfA3, 5);
    chk("rel_wd", RfWD, 32'h1234);
    chk("rel_ready", McReady, 1);
    tick();

    // single result, port free
    idle(); offer(5'd7, 32'hDEAD); #1;
    chk("t2_ready0", McReady, 1);
    chk("t2_we0", RfWE, 0);
    tick();
    idle(); pipe(5'd0, 32'hFFFF); Rs1D = 5'd7; #1;
    chk("t2_we1", RfWE, 1);
    chk("t2_a3", RfA3, 7);
    chk("t2_wd", RfWD, 32'hDEAD);
    chk("t2_ready1", McReady, 1);
    chk("t2_busy_pop", Busy1, 1);
    tick();
    idle(); Rs1D = 5'd7; #1;
    chk("t2_we2", RfWE, 0);
    chk("t2_busy_gone", Busy1, 0);
    tick();

    // FIFO fill while pipeline busy
    idle(); pipe(5'd1, 32'h100); offer(5'd10, 32'hA); #1;
    chk("t3_ready0", McReady, 1);
    chk("t3_pipe_wd", RfWD, 32'h100);
    tick();
    pipe(5'd2, 32'h200); offer(5'd11, 32'hB); #1;
    chk("t3_ready1", McReady, 1);
    chk("t3_pipe_a3", RfA3, 2);
    tick();
    pipe(5'd3, 32'h300); offer(5'd12, 32'hC); #1;
    chk("t3_ready2", McReady, 0);
    tick();
    idle(); Rs2D = 5'd11; #1;
    chk("t3_a3_first", RfA3, 10);
    chk("t3_wd_first", RfWD, 32'hA);
    chk("t3_busy2", Busy2, 1);
    tick();
    idle(); #1;
    chk("t3_a3_second", RfA3, 11);
    chk("t3_wd_second", RfWD, 32'hB);
    tick();
    idle(); #1;
    chk("t3_we_empty", RfWE, 0);
    chk("t3_ready_empty", McReady, 1);
    tick();

    // WAW kill of a buffered entry
    idle(); pipe(5'd2, 32'h22); offer(5'd9, 32'h99); Rs1D = 5'd9; #1;
    chk("t4_busy_offer", Busy1, 0);
    tick();
    idle(); pipe(5'd9, 32'h909); Rs1D = 5'd9; #1;
    chk("t4_busy_held", Busy1, 1);
    chk("t4_pipe_wd", RfWD, 32'h909);
    tick();
    idle(); Rs1D = 5'd9; #1;
    chk("t4_busy_drop", Busy1, 0);
    chk("t4_no_stale", RfWE, 0);
    tick();
    idle(); #1;
    chk("t4_we_after", RfWE, 0);
    chk("t4_ready", McReady, 1);
    tick();

    // killed head skipped, next entry written at once
    idle(); pipe(5'd1, 32'h1); offer(5'd13, 32'hAAA); #1;
    tick();
    idle(); pipe(5'd13, 32'h13); offer(5'd14, 32'hBBB); #1;
    chk("t5_ready", McReady, 1);
    tick();
    idle(); #1;
    chk("t5_skip_a3", RfA3, 14);
    chk("t5_skip_wd", RfWD, 32'hBBB);
    tick();
    idle(); #1;
    chk("t5_we_empty", RfWE, 0);
    tick();

    // McRd = 0 is acknowledged and dropped
    idle(); offer(5'd0, 32'h5555); Rs1D = 5'd3; #1;
    chk("t6_ready", McReady, 1);
    chk("t6_busy", Busy1, 0);
    tick();
    idle(); Rs1D = 5'd3; #1;
    chk("t6_we", RfWE, 0);
    chk("t6_busy_after", Busy1, 0);
    tick();

    // starvation: one buffered entry, eight pipeline writes
    idle(); pipe(5'd1, 32'h1); offer(5'd20, 32'h2020); #1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      idle(); pipe(5'd1, 32'h1); #1;
      if (c == 8) chk("t7_stall_pre", StallReq, 0);
      tick();
    end
    idle(); pipe(5'd1, 32'h1); #1;
    chk("t7_stall", StallReq, STARVE ? 1 : 0);
    tick();
    idle(); #1;
    chk("t7_bubble_a3", RfA3, 20);
    chk("t7_stall_bubble", StallReq, STARVE ? 1 : 0);
    tick();
    idle(); #1;
    chk("t7_stall_clear", StallReq, 0);
    tick();

    // mid-operation reset discards buffered results
    idle(); pipe(5'd1, 32'h1); offer(5'd21, 32'h2121); #1;
    tick();
    idle(); Rs1D = 5'd21; rst_n = 1'b0; #1;
    chk("t8_ready_rst", McReady, 0);
    chk("t8_we_rst", RfWE, 0);
    chk("t8_busy_rst", Busy1, 0);
    tick();
    rst_n = 1'b1; #1;
    chk("t8_ready_rel", McReady, 1);
    chk("t8_we_rel", RfWE, 0);
    chk("t8_busy_rel", Busy1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of multi-cycle result buffer entries (legal values 1 to 4).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set the number of consecutive lost-arbitration cycles before a stall request is raised.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 RegWriteW  in  1  SHALL be the pipeline write-back enable.
REQ-006 RdW  in  5  SHALL be the pipeline destination register.
REQ-007 ResultW  in  32  SHALL be the pipeline write-back data.
REQ-008 McValid  in  1  SHALL indicate that a multi-cycle unit result is offered.
REQ-009 McRd  in  5 / McData  in  32  SHALL be the multi-cycle destination register and result.
REQ-010 McReady  out  1  SHALL indicate that the arbiter accepts the offered result this cycle.
REQ-011 RfWE  out  1 / RfA3  out  5 / RfWD  out  32  SHALL drive the single register-file write port.
REQ-012 Rs1D  in  5 / Rs2D  in  5  SHALL be the decode-stage source registers to check.
REQ-013 Busy1  out  1 / Busy2  out  1  SHALL flag a pending buffered write to Rs1D / Rs2D.
REQ-014 StallReq  out  1  SHALL request a one-cycle write-back bubble from the hazard unit.

Function
REQ-015 Acceptance SHALL occur when McValid and McReady are both high; McReady SHALL equal (count < DEPTH), computed from registered state only.
REQ-016 An accepted result with McRd = 0 SHALL be acknowledged and discarded, never buffered.
REQ-017 The buffer SHALL be a FIFO; an entry accepted in cycle N SHALL become eligible for the port no earlier than cycle N+1.
REQ-018 A pipeline write is active when RegWriteW = 1 and RdW != 0; an active pipeline write SHALL always win the port, and RfWE/RfA3/RfWD SHALL be combinational copies of RegWriteW/RdW/ResultW.
REQ-019 When no pipeline write is active and the FIFO head is valid, the port SHALL write the head entry and the FIFO SHALL pop at the clock edge.
REQ-020 When neither source is active, RfWE SHALL be 0 and RfA3/RfWD SHALL be 0.
REQ-021 An active pipeline write whose RdW matches any valid buffered entry SHALL invalidate that entry (WAW kill); invalidated entries SHALL be skipped without using a port cycle.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; the FIFO pointers SHALL wrap modulo DEPTH.
REQ-023 BusyN SHALL be 1 when RsND != 0 and a valid buffered entry has that Rd, including an entry popping this cycle.
REQ-024 Busy flags SHALL NOT consider the McRd value being offered in the same cycle.

Reset
REQ-025 While rst_n = 0: FIFO empty, all entries invalid, starvation counter 0, McReady 0, RfWE 0, Busy1/Busy2 0, StallReq 0, regardless of the other inputs.
REQ-026 Reset asserted mid-operation SHALL discard all buffered results; McReady SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-027 With WB_ARB_STARVE_EN defined, a saturating counter SHALL increment on each cycle with the FIFO non-empty and an active pipeline write, and SHALL clear on a FIFO pop or when the FIFO is empty.
REQ-028 With WB_ARB_STARVE_EN defined, StallReq SHALL be 1 while the counter equals STARVE_LIMIT.
REQ-029 Without WB_ARB_STARVE_EN, no counter SHALL exist and StallReq SHALL be tied to 0.

Verification
REQ-030 rst_n low and RegWriteW=1 RdW=5 -> RfWE=0 and McReady=0; then rst_n high -> RfWE=1 RfA3=5 and McReady=1.
REQ-031 Accept McRd=7 McData=0xDEAD in cycle 0 with no pipeline write -> RfWE=1 RfA3=7 RfWD=0xDEAD in cycle 1, McReady=1 throughout.
REQ-032 Three results offered back-to-back while the pipeline writes every cycle (DEPTH=2) -> McReady=0 on the third offer; buffered results retire in FIFO order once the pipeline idles.
REQ-033 Buffer McRd=9, then pipeline writes RdW=9 -> the entry is killed, Busy1 with Rs1D=9 drops the following cycle, and no stale write of x9 occurs.
REQ-034 With WB_ARB_STARVE_EN, buffered entry plus 8 consecutive pipeline writes -> StallReq=1; a bubble cycle pops the entry and clears StallReq the next cycle.
REQ-035 Offer McRd=0 -> accepted, with no buffer occupancy, no RfWE and Busy flags unchanged.
